// File: rtl/balsa_sync_sink.sv
// Four-phase bundled-data push sink feeding a valid/ready FIFO; acks SYNC_STAGES+1 edges after request, withheld while full.
// Optional saturating stall counter port stall_cnt enabled by BALSA_SYNC_SINK_STALL_CNT_EN.
module balsa_sync_sink #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     initialise,
  input  logic                     o_0r,
  output logic                     o_0a,
  input  logic [WIDTH-1:0]         o_0d,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count
`ifdef BALSA_SYNC_SINK_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic [AW:0]            rd_next;
  logic [WIDTH-1:0]       mem [DEPTH];
  logic                   full;
  logic                   push_ok;
  logic                   push;
  logic                   pop;

  // Request crosses into clk here; o_0d is sampled raw because it is already stable by the time req_s rises.
  always_ff @(posedge clk or posedge initialise) begin
    if (initialise) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], o_0r};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  assign count     = wr_ptr - rd_ptr;
  assign out_valid = (wr_ptr != rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = out_valid && out_ready;
  assign push_ok   = !full || pop;
  assign rd_next   = rd_ptr + 1'b1;

  always_ff @(posedge clk or posedge initialise) begin
    if (initialise) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // One write per four-phase cycle: the write only happens on the IDLE->ACK transition.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s && push_ok) begin
          push    = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!req_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_0a = (state_q == ACK);

  always_ff @(posedge clk or posedge initialise) begin
    if (initialise) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= o_0d;
    end
  end

  // Registered head: loads the incoming byte when it becomes the head, holds when the FIFO drains empty.
  always_ff @(posedge clk or posedge initialise) begin
    if (initialise) begin
      out_data <= '0;
    end else if (push && (!out_valid || (pop && count == CNT_ONE))) begin
      out_data <= o_0d;
    end else if (pop && count > CNT_ONE) begin
      out_data <= mem[rd_next[AW-1:0]];
    end
  end

`ifdef BALSA_SYNC_SINK_STALL_CNT_EN
  logic stall;

  assign stall = (state_q == IDLE) && req_s && !push_ok;

  always_ff @(posedge clk or posedge initialise) begin
    if (initialise) begin
      stall_cnt <= '0;
    end else if (stall && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_balsa_sync_sink.sv
// Bench for balsa_sync_sink: scenario tasks plus a queue scoreboard checking order, occupancy and valid.
module tb_balsa_sync_sink;

  logic       clk = 1'b0;
  logic       initialise = 1'b1;
  logic       o_0r = 1'b0;
  logic       o_0a;
  logic [7:0] o_0d = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [2:0] count;
`ifdef BALSA_SYNC_SINK_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int         chk_cnt = 0;
  int         pass_cnt = 0;
  int         pop_total = 0;
  logic [7:0] model_q[$];
  logic       prev_ack = 1'b0;
  logic       done = 1'b0;

  always #5 clk = ~clk;

  balsa_sync_sink #(
    .WIDTH(8),
    .DEPTH(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .initialise(initialise),
    .o_0r(o_0r),
    .o_0a(o_0a),
    .o_0d(o_0d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .count(count)
`ifdef BALSA_SYNC_SINK_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  // Scoreboard: a byte enters on each ack rise, leaves on each cycle with valid&ready ahead of the next edge.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (initialise) begin
      model_q.delete();
      prev_ack = 1'b0;
    end else begin
      if (o_0a === 1'b1 && !prev_ack) model_q.push_back(o_0d);
      prev_ack = (o_0a === 1'b1);
      chk_cnt++;
      if (count !== 3'(model_q.size()))
        $display("FAIL sb_count got %0d want %0d at %0t", count, model_q.size(), $time);
      else pass_cnt++;
      chk_cnt++;
      if (out_valid !== (model_q.size() != 0))
        $display("FAIL sb_valid got %b want %b at %0t", out_valid, model_q.size() != 0, $time);
      else pass_cnt++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        exp_b = (model_q.size() != 0) ? model_q[0] : 8'hxx;
        chk_cnt++;
        if (model_q.size() == 0 || out_data !== exp_b)
          $display("FAIL sb_data got %02h want %02h at %0t", out_data, exp_b, $time);
        else pass_cnt++;
        if (model_q.size() != 0) void'(model_q.pop_front());
        pop_total++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, output bit ok);
    int n;
    o_0d = b;
    o_0r = 1'b1;
    n = 0;
    while (o_0a !== 1'b1 && n < 200) begin tick(); n++; end
    ok = (o_0a === 1'b1);
    o_0r = 1'b0;
    n = 0;
    while (o_0a !== 1'b0 && n < 200) begin tick(); n++; end
    ok = ok && (o_0a === 1'b0);
  endtask

  task automatic drain(output bit ok);
    int n;
    out_ready = 1'b1;
    n = 0;
    while (out_valid !== 1'b0 && n < 300) begin tick(); n++; end
    tick();
    ok = (out_valid === 1'b0);
  endtask

  task automatic test_reset();
    initialise = 1'b1;
    repeat (3) tick();
    chk_cnt++; if (o_0a !== 1'b0) $display("FAIL rst_ack got %b want 0", o_0a); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (count !== 3'd0) $display("FAIL rst_count got %0d want 0", count); else pass_cnt++;
    chk_cnt++; if (out_data !== 8'h00) $display("FAIL rst_data got %02h want 00", out_data); else pass_cnt++;
`ifdef BALSA_SYNC_SINK_STALL_CNT_EN
    chk_cnt++; if (stall_cnt !== 16'd0) $display("FAIL rst_stall got %0d want 0", stall_cnt); else pass_cnt++;
`endif
    initialise = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int e;
    out_ready = 1'b1;
    o_0d = 8'hA5;
    tick();
    o_0r = 1'b1;
    e = 0;
    while (o_0a !== 1'b1 && e < 20) begin tick(); e++; end
    chk_cnt++; if (e != 3) $display("FAIL single_rise_lat got %0d want 3", e); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL single_valid got %b want 1", out_valid); else pass_cnt++;
    chk_cnt++; if (out_data !== 8'hA5) $display("FAIL single_data got %02h want a5", out_data); else pass_cnt++;
    tick();
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL single_popped got %b want 0", out_valid); else pass_cnt++;
    o_0r = 1'b0;
    e = 0;
    while (o_0a !== 1'b0 && e < 20) begin tick(); e++; end
    chk_cnt++; if (e != 3) $display("FAIL single_fall_lat got %0d want 3", e); else pass_cnt++;
    tick();
  endtask

  task automatic test_backpressure();
    bit ok;
    int p0;
    int n;
`ifdef BALSA_SYNC_SINK_STALL_CNT_EN
    logic [15:0] s0;
`endif
    out_ready = 1'b0;
    tick();
    for (int i = 1; i <= 4; i++) begin
      send(8'(i), ok);
      chk_cnt++; if (!ok) $display("FAIL fill_ack got 0 want 1 (byte %0d)", i); else pass_cnt++;
    end
    chk_cnt++; if (count !== 3'd4) $display("FAIL fill_count got %0d want 4", count); else pass_cnt++;
`ifdef BALSA_SYNC_SINK_STALL_CNT_EN
    s0 = stall_cnt;
`endif
    o_0d = 8'h05;
    o_0r = 1'b1;
    repeat (10) tick();
    chk_cnt++; if (o_0a !== 1'b0) $display("FAIL full_noack got %b want 0", o_0a); else pass_cnt++;
    chk_cnt++; if (count !== 3'd4) $display("FAIL full_count got %0d want 4", count); else pass_cnt++;
`ifdef BALSA_SYNC_SINK_STALL_CNT_EN
    chk_cnt++;
    if (stall_cnt - s0 !== 16'd8) $display("FAIL stall_delta got %0d want 8", stall_cnt - s0);
    else pass_cnt++;
`endif
    p0 = pop_total;
    out_ready = 1'b1;
    tick();
    chk_cnt++; if (count !== 3'd4) $display("FAIL pushpop_count got %0d want 4", count); else pass_cnt++;
    chk_cnt++; if (o_0a !== 1'b1) $display("FAIL pushpop_ack got %b want 1", o_0a); else pass_cnt++;
    o_0r = 1'b0;
    n = 0;
    while (o_0a !== 1'b0 && n < 50) begin tick(); n++; end
    drain(ok);
    chk_cnt++; if (!ok) $display("FAIL bp_drain got busy want empty"); else pass_cnt++;
    chk_cnt++; if (pop_total - p0 != 5) $display("FAIL bp_pops got %0d want 5", pop_total - p0); else pass_cnt++;
  endtask

  task automatic test_wrap();
    bit ok;
    bit all_ok;
    int p0;
    p0 = pop_total;
    all_ok = 1'b1;
    out_ready = 1'b0;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send(8'(8'h10 + i), ok);
          all_ok = all_ok && ok;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin tick(); out_ready = ~out_ready; end
      end
    join
    chk_cnt++; if (!all_ok) $display("FAIL wrap_acks got 0 want 1"); else pass_cnt++;
    drain(ok);
    chk_cnt++; if (pop_total - p0 != 10) $display("FAIL wrap_pops got %0d want 10", pop_total - p0); else pass_cnt++;
  endtask

  task automatic test_long_req();
    int n;
    bit ok;
    out_ready = 1'b0;
    o_0d = 8'h77;
    o_0r = 1'b1;
    n = 0;
    while (o_0a !== 1'b1 && n < 50) begin tick(); n++; end
    repeat (20) tick();
    chk_cnt++; if (count !== 3'd1) $display("FAIL long_count got %0d want 1", count); else pass_cnt++;
    chk_cnt++; if (o_0a !== 1'b1) $display("FAIL long_ack got %b want 1", o_0a); else pass_cnt++;
    o_0r = 1'b0;
    n = 0;
    while (o_0a !== 1'b0 && n < 50) begin tick(); n++; end
    chk_cnt++; if (count !== 3'd1) $display("FAIL long_count_after got %0d want 1", count); else pass_cnt++;
    drain(ok);
    chk_cnt++; if (count !== 3'd0) $display("FAIL long_drain got %0d want 0", count); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    int p0;
    out_ready = 1'b0;
    send(8'hAA, ok);
    send(8'hBB, ok);
    o_0d = 8'hCC;
    o_0r = 1'b1;
    n = 0;
    while (o_0a !== 1'b1 && n < 50) begin tick(); n++; end
    chk_cnt++; if (count !== 3'd3) $display("FAIL mid_pre_count got %0d want 3", count); else pass_cnt++;
    #2;
    initialise = 1'b1;
    #1;
    chk_cnt++; if (o_0a !== 1'b0) $display("FAIL mid_ack got %b want 0", o_0a); else pass_cnt++;
    chk_cnt++; if (count !== 3'd0) $display("FAIL mid_count got %0d want 0", count); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_valid got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_data !== 8'h00) $display("FAIL mid_data got %02h want 00", out_data); else pass_cnt++;
    o_0r = 1'b0;
    repeat (2) tick();
    initialise = 1'b0;
    tick();
    p0 = pop_total;
    out_ready = 1'b1;
    send(8'h3C, ok);
    chk_cnt++; if (!ok) $display("FAIL mid_next_ack got 0 want 1"); else pass_cnt++;
    drain(ok);
    chk_cnt++; if (pop_total - p0 != 1) $display("FAIL mid_next_pops got %0d want 1", pop_total - p0); else pass_cnt++;
  endtask

  task automatic test_random();
    bit ok;
    bit all_ok;
    int p0;
    p0 = pop_total;
    all_ok = 1'b1;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          send(8'($urandom), ok);
          all_ok = all_ok && ok;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin tick(); out_ready = 1'($urandom_range(0, 1)); end
      end
    join
    chk_cnt++; if (!all_ok) $display("FAIL rand_acks got 0 want 1"); else pass_cnt++;
    drain(ok);
    chk_cnt++; if (pop_total - p0 != 30) $display("FAIL rand_pops got %0d want 30", pop_total - p0); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_wrap();
    test_long_req();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
